// File: rtl/fx_sample_sequencer.sv
// fx_sample_sequencer
// Per-sample controller between the audio receiver and the FIR_LPF effect
// datapath. Each accepted sample is handed to the filter as a one-cycle
// strobe. After a fixed latency, either the filter result (wet) or the
// untouched input (dry) is emitted. The block also debounces the bypass
// footswitch, runs the BYPASS/FILL/ACTIVE mode machine and slews the filter
// gain by one step per sample.
module fx_sample_sequencer #(
  parameter int         FX_LAT     = 2,     // fx_en strobe to fx_dout valid, >= 1
  parameter int         FILL_N     = 16,    // samples fed before wet output is used, >= 1
  parameter int         DEB_CYCLES = 1000,  // footswitch stable time in clocks, >= 2
  parameter logic [2:0] GAIN_RST   = 3'd1   // fx_gain after reset
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_valid,
  input  logic [23:0] s_data,
  output logic        s_ready,
  input  logic [2:0]  gain_tgt,
  input  logic        sw_in,
  output logic        fx_en,
  output logic [23:0] fx_din,
  output logic [2:0]  fx_gain,
  input  logic [23:0] fx_dout,
  output logic        m_valid,
  output logic [23:0] m_data,
  output logic [1:0]  mode,
  output logic        overrun
);

  typedef enum logic [1:0] {
    MODE_BYPASS = 2'd0,
    MODE_FILL   = 2'd1,
    MODE_ACTIVE = 2'd2
  } mode_t;

  localparam int DEB_W  = $clog2(DEB_CYCLES);
  localparam int LAT_W  = $clog2(FX_LAT + 1);
  localparam int FILL_W = $clog2(FILL_N + 1);

  localparam logic [DEB_W-1:0]  DEB_MAX  = DEB_W'(DEB_CYCLES - 1);
  localparam logic [LAT_W-1:0]  LAT_LAST = LAT_W'(FX_LAT);
  localparam logic [FILL_W-1:0] FILL_END = FILL_W'(FILL_N);

  // ---------------------------------------------------------------------------
  // Footswitch synchroniser and debouncer
  // ---------------------------------------------------------------------------
  logic             sw_meta;
  logic             sw_sync;
  logic             sw_prev;
  logic             sw_stable;
  logic [DEB_W-1:0] deb_cnt;
  logic             sw_settled;
  logic             press;

  // Two-flop synchroniser for the asynchronous footswitch.
  always_ff @(posedge clk) begin
    // NOTE: every clocked process uses non-blocking assignments so that all
    // flops sample their inputs from the same pre-edge values.
    if (rst) begin
      sw_meta <= 1'b0;
      sw_sync <= 1'b0;
    end else begin
      sw_meta <= sw_in;
      sw_sync <= sw_meta;
    end
  end

  // The synced value has not changed since last cycle and has been steady
  // long enough; this is the cycle the stable value is allowed to follow it.
  assign sw_settled = (sw_sync == sw_prev) && (deb_cnt == DEB_MAX);

  // A press is the rising edge of the debounced value, flagged in the same
  // cycle the stable value is updated so the FSM reacts without extra delay.
  assign press = sw_settled && sw_sync && !sw_stable;

  // Debounce timer: any change of the synced value restarts the count; once it
  // has held for DEB_CYCLES cycles the stable value takes the synced value.
  always_ff @(posedge clk) begin
    if (rst) begin
      sw_prev   <= 1'b0;
      deb_cnt   <= '0;
      sw_stable <= 1'b0;
    end else begin
      sw_prev <= sw_sync;
      if (sw_sync != sw_prev) begin
        deb_cnt <= '0;
      end else if (deb_cnt != DEB_MAX) begin
        deb_cnt <= deb_cnt + 1'b1;
      end
      if (sw_settled) begin
        sw_stable <= sw_sync;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Mode FSM
  // ---------------------------------------------------------------------------
  mode_t             state;
  mode_t             state_next;
  logic              fill_clr;
  logic [FILL_W-1:0] fill_cnt;

  // Mode state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= MODE_BYPASS;
    end else begin
      state <= state_next;
    end
  end

  // Next-mode logic; a press always beats fill completion in the same cycle.
  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch
    // is inferred.
    state_next = state;
    fill_clr   = 1'b0;
    case (state)
      MODE_BYPASS: begin
        if (press) begin
          state_next = MODE_FILL;
          fill_clr   = 1'b1;
        end
      end
      MODE_FILL: begin
        if (press) begin
          state_next = MODE_BYPASS;
        end else if (fill_cnt == FILL_END) begin
          state_next = MODE_ACTIVE;
        end
      end
      MODE_ACTIVE: begin
        if (press) begin
          state_next = MODE_BYPASS;
        end
      end
      default: begin
        state_next = MODE_BYPASS;
      end
    endcase
  end

  assign mode = state;

  // ---------------------------------------------------------------------------
  // Sample pipeline control
  // ---------------------------------------------------------------------------
  logic             busy;
  logic [LAT_W-1:0] lat_cnt;
  logic [23:0]      dry;
  mode_t            lat_mode;
  logic             accept;
  logic             complete;

  assign accept   = s_valid && !busy;
  assign complete = busy && (lat_cnt == LAT_LAST);
  assign s_ready  = !busy;

  // In-flight sample tracking. The dry sample and its mode are held for the
  // whole flight, which delays the dry path to match the filter latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy     <= 1'b0;
      lat_cnt  <= '0;
      dry      <= '0;
      lat_mode <= MODE_BYPASS;
    end else if (accept) begin
      busy     <= 1'b1;
      lat_cnt  <= '0;
      dry      <= s_data;
      lat_mode <= state;
    end else if (busy) begin
      if (complete) begin
        busy <= 1'b0;
      end else begin
        lat_cnt <= lat_cnt + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Filter interface and gain slew
  // ---------------------------------------------------------------------------
  logic [2:0] gain_next;

  // One gain step toward gain_tgt; the target is itself in 0..7, so
  // stepping toward it can never wrap.
  always_comb begin
    gain_next = fx_gain;
    if (gain_tgt > fx_gain) begin
      gain_next = fx_gain + 3'd1;
    end else if (gain_tgt < fx_gain) begin
      gain_next = fx_gain - 3'd1;
    end
  end

  // Filter strobe, sample and gain, all updated in the cycle after accept.
  // The gain slews in every mode so re-engaging never jumps the level.
  always_ff @(posedge clk) begin
    if (rst) begin
      fx_en   <= 1'b0;
      fx_din  <= '0;
      fx_gain <= GAIN_RST;
    end else begin
      fx_en <= accept && (state != MODE_BYPASS);
      if (accept) begin
        fx_din  <= s_data;
        fx_gain <= gain_next;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output, fill counting and overrun
  // ---------------------------------------------------------------------------

  // Output capture: wet only for samples that entered while ACTIVE.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_data  <= '0;
    end else begin
      m_valid <= complete;
      if (complete) begin
        m_data <= (lat_mode == MODE_ACTIVE) ? fx_dout : dry;
      end
    end
  end

  // Count samples pushed through the filter while filling, saturating at
  // FILL_N; entering FILL restarts the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      fill_cnt <= '0;
    end else if (fill_clr) begin
      fill_cnt <= '0;
    end else if (complete && (lat_mode == MODE_FILL) && (fill_cnt != FILL_END)) begin
      fill_cnt <= fill_cnt + 1'b1;
    end
  end

  // Sticky overrun: a strobe arriving while busy is dropped and remembered.
  always_ff @(posedge clk) begin
    if (rst) begin
      overrun <= 1'b0;
    end else if (s_valid && busy) begin
      overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fx_sample_sequencer.sv
// Testbench for fx_sample_sequencer: directed sequence with random sample data
// and gain targets, checked against a transaction-level reference model.
module tb_fx_sample_sequencer;

  localparam int FX_LAT     = 2;
  localparam int FILL_N     = 4;
  localparam int DEB_CYCLES = 4;
  localparam int GAIN_RST   = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_valid = 1'b0;
  logic [23:0] s_data = '0;
  logic        s_ready;
  logic [2:0]  gain_tgt = 3'd1;
  logic        sw_in = 1'b0;
  logic        fx_en;
  logic [23:0] fx_din;
  logic [2:0]  fx_gain;
  logic [23:0] fx_dout;
  logic        m_valid;
  logic [23:0] m_data;
  logic [1:0]  mode;
  logic        overrun;

  fx_sample_sequencer #(
    .FX_LAT    (FX_LAT),
    .FILL_N    (FILL_N),
    .DEB_CYCLES(DEB_CYCLES),
    .GAIN_RST  (3'(GAIN_RST))
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .s_valid (s_valid),
    .s_data  (s_data),
    .s_ready (s_ready),
    .gain_tgt(gain_tgt),
    .sw_in   (sw_in),
    .fx_en   (fx_en),
    .fx_din  (fx_din),
    .fx_gain (fx_gain),
    .fx_dout (fx_dout),
    .m_valid (m_valid),
    .m_data  (m_data),
    .mode    (mode),
    .overrun (overrun)
  );

  always #5 clk = ~clk;

  // Stand-in filter with an FX_LAT=2 pipeline; its transform never returns
  // the input unchanged, so wet and dry are always distinguishable.
  function automatic logic [23:0] wet(input logic [23:0] x);
    return x ^ 24'hA5A5A5;
  endfunction

  logic [23:0] f_stage = '0;
  initial fx_dout = '0;
  always @(posedge clk) begin
    if (fx_en) f_stage <= wet(fx_din);
    fx_dout <= f_stage;
  end

  // Count output strobes seen on rising edges.
  int mv_count = 0;
  always @(posedge clk) if (m_valid === 1'b1) mv_count++;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state.
  int model_mode = 0;  // 0 bypass, 1 fill, 2 active
  int model_fill = 0;
  int model_gain = GAIN_RST;
  logic model_ovr = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_fx_en"},   32'(fx_en),   32'd0);
    check({tag, "_fx_din"},  32'(fx_din),  32'd0);
    check({tag, "_fx_gain"}, 32'(fx_gain), 32'(GAIN_RST));
    check({tag, "_m_valid"}, 32'(m_valid), 32'd0);
    check({tag, "_m_data"},  32'(m_data),  32'd0);
    check({tag, "_mode"},    32'(mode),    32'd0);
    check({tag, "_overrun"}, 32'(overrun), 32'd0);
    check({tag, "_s_ready"}, 32'(s_ready), 32'd1);
  endtask

  // Advance the model gain by one slew step toward gain_tgt.
  task automatic model_gain_step();
    if (int'(gain_tgt) > model_gain) model_gain++;
    else if (int'(gain_tgt) < model_gain) model_gain--;
  endtask

  // Wait for the output strobe of a sample accepted on the previous edge.
  // Called at the negedge just after the accept edge.
  task automatic wait_output(input string tag, input logic [23:0] exp);
    int lat = 0;
    bit got = 0;
    while (!got && lat < 20) begin
      if (m_valid === 1'b1) got = 1;
      else begin
        @(negedge clk);
        lat++;
      end
    end
    check({tag, "_got"},     32'(got),     32'd1);
    check({tag, "_latency"}, 32'(lat),     32'(FX_LAT + 1));
    check({tag, "_m_data"},  32'(m_data),  32'(exp));
    check({tag, "_s_ready"}, 32'(s_ready), 32'd1);
  endtask

  // One complete sample transaction from an idle sequencer.
  task automatic send(input string tag, input logic [23:0] d);
    int lmode = model_mode;
    logic [23:0] exp;
    model_gain_step();
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = d;
    @(negedge clk);
    s_valid = 1'b0;
    s_data  = $urandom;
    check({tag, "_fx_en"},   32'(fx_en),   32'(lmode != 0));
    check({tag, "_fx_din"},  32'(fx_din),  32'(d));
    check({tag, "_fx_gain"}, 32'(fx_gain), 32'(model_gain));
    check({tag, "_busy"},    32'(s_ready), 32'd0);
    exp = (lmode == 2) ? wet(d) : d;
    wait_output(tag, exp);
    if (lmode == 1 && model_fill < FILL_N) model_fill++;
    if (model_mode == 1 && model_fill == FILL_N) model_mode = 2;
    repeat (3) @(negedge clk);
    check({tag, "_hold"},    32'(m_data),  32'(exp));
    check({tag, "_mode"},    32'(mode),    32'(model_mode));
    check({tag, "_overrun"}, 32'(overrun), 32'(model_ovr));
  endtask

  // Press and release the footswitch, expecting one mode toggle.
  task automatic do_press(input string tag);
    int exp_mode = (model_mode == 0) ? 1 : 0;
    int n = 0;
    if (exp_mode == 1) model_fill = 0;
    @(negedge clk);
    sw_in = 1'b1;
    while (mode !== 2'(exp_mode) && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_mode"},     32'(mode), 32'(exp_mode));
    check({tag, "_debounce"}, 32'(n >= DEB_CYCLES), 32'd1);
    model_mode = exp_mode;
    repeat (10) @(negedge clk);
    sw_in = 1'b0;
    repeat (DEB_CYCLES + 8) @(negedge clk);
    check({tag, "_release"}, 32'(mode), 32'(model_mode));
  endtask

  function automatic logic [23:0] sine(input int k);
    int s = $rtoi(120.0 * $sin(2.0 * 3.14159265358979 * real'(k) / 64.0));
    return 24'(s);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int mv_snap;

    // Reset
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset_vals("reset");

    // Bypass sample of -120 and gain slew up toward 4
    gain_tgt = 3'd4;
    send("bypass_m120", 24'hFFFF88);
    for (int i = 0; i < 3; i++) send("gain_up", 24'($urandom));
    gain_tgt = 3'd0;
    for (int i = 0; i < 5; i++) send("gain_down", 24'($urandom));

    // Glitch on the footswitch shorter than the debounce window
    @(negedge clk);
    sw_in = 1'b1;
    repeat (2) @(negedge clk);
    sw_in = 1'b0;
    repeat (12) @(negedge clk);
    check("glitch_mode", 32'(mode), 32'd0);

    // Engage: first FILL_N sine samples dry, then wet
    do_press("engage");
    for (int k = 0; k < FILL_N + 3; k++) begin
      gain_tgt = 3'($urandom_range(0, 7));
      send("fill_sine", sine(k));
    end
    check("active_mode", 32'(mode), 32'd2);

    // Overrun: two consecutive strobes, the second is dropped
    begin
      logic [23:0] d1 = 24'($urandom);
      model_gain_step();
      mv_snap = mv_count;
      @(negedge clk);
      s_valid = 1'b1;
      s_data  = d1;
      @(negedge clk);
      s_data  = 24'($urandom);
      check("ovr_gain", 32'(fx_gain), 32'(model_gain));
      @(negedge clk);
      s_valid = 1'b0;
      model_ovr = 1'b1;
      while (m_valid !== 1'b1 && mv_count - mv_snap < 2 && $time < 190000) @(negedge clk);
      check("ovr_first_data", 32'(m_data), 32'(wet(d1)));
      repeat (10) @(negedge clk);
      check("ovr_one_output", 32'(mv_count - mv_snap), 32'd1);
      check("ovr_flag", 32'(overrun), 32'd1);
    end

    // Disengage from ACTIVE, bypassed sample is dry and overrun sticks
    do_press("disengage");
    send("bypass_after", 24'($urandom));

    // Press during FILL after 2 samples returns to BYPASS
    do_press("engage2");
    send("fill2_a", 24'($urandom));
    send("fill2_b", 24'($urandom));
    do_press("abort_fill");
    send("bypass_after_fill", 24'($urandom));

    // Reset one cycle after an accept aborts the in-flight sample
    do_press("engage3");
    gain_tgt = 3'd7;
    mv_snap = mv_count;
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = 24'($urandom);
    @(negedge clk);
    s_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_mode = 0;
    model_fill = 0;
    model_gain = GAIN_RST;
    model_ovr  = 1'b0;
    gain_tgt   = 3'(GAIN_RST);
    check_reset_vals("midrst");
    repeat (8) @(negedge clk);
    check("midrst_no_output", 32'(mv_count - mv_snap), 32'd0);
    check("midrst_m_data", 32'(m_data), 32'd0);

    // Fill restarts from zero after reset
    do_press("engage4");
    for (int i = 0; i < FILL_N - 1; i++) send("refill", 24'($urandom));
    check("refill_mode", 32'(mode), 32'd1);
    send("refill_last", 24'($urandom));
    check("refill_active", 32'(mode), 32'd2);
    send("refill_wet", 24'($urandom));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
